// File: rtl/dn_mem_sink_if.sv
// rtl/dn_mem_sink_if.sv - download stream, memory write port and CPU control bundle for dn_mem_sink
interface dn_mem_sink_if #(
    parameter int ADDR_W = 16
);
    logic              dn_go;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [7:0]        dn_data;
    logic              dn_wait;
    logic [ADDR_W-1:0] execute_addr;
    logic              execute_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout;
    logic              mem_wr_req;
    logic              mem_ack;
    logic              cpu_hold;
    logic              cpu_jump;
    logic [ADDR_W-1:0] cpu_jump_addr;
    logic [ADDR_W:0]   byte_count;
    logic              overflow;
    logic [7:0]        checksum;

    modport slave (
        input  dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
        output dn_wait, mem_addr, mem_dout, mem_wr_req, cpu_hold, cpu_jump,
               cpu_jump_addr, byte_count, overflow, checksum
    );

    modport master (
        output dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, mem_ack,
        input  dn_wait, mem_addr, mem_dout, mem_wr_req, cpu_hold, cpu_jump,
               cpu_jump_addr, byte_count, overflow, checksum
    );
endinterface

// File: rtl/dn_mem_sink.sv
// rtl/dn_mem_sink.sv - download byte sink: FIFO to memory write port, CPU hold/jump control
// Optional running checksum of written bytes when DN_CHECKSUM_EN is defined.
module dn_mem_sink #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    dn_mem_sink_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   WAIT_CNT = (PTR_W+1)'(FIFO_DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W:0]  BC_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, JUMP} state_t;

    state_t            state_q, state_d;
    logic              go_prev_q;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]        fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d, cnt_after_pop;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        mdout_q, mdout_d;
    logic              hold_q, hold_d;
    logic              exec_q, exec_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [ADDR_W:0]   bcount_q, bcount_d;
    logic              ovf_q, ovf_d;

    logic go_rise, active, full, pop, push, drop, start, req_hold;

    assign go_rise  = bus.dn_go && !go_prev_q;
    assign active   = (state_q == LOAD) || (state_q == DRAIN);
    assign full     = (count_q == FULL_CNT);
    assign pop      = active && req_q && bus.mem_ack;
    assign push     = (state_q == LOAD) && bus.dn_go && bus.dn_wr && (!full || pop);
    assign drop     = (state_q == LOAD) && bus.dn_go && bus.dn_wr && full && !pop;
    assign start    = go_rise && ((state_q == IDLE) || (state_q == DRAIN));
    assign req_hold = req_q && !bus.mem_ack;

    // The presented head stays in the FIFO until acked, so occupancy counts it.
    always_comb begin
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        cnt_after_pop = pop  ? count_q - CNT_ONE  : count_q;
        count_d       = push ? cnt_after_pop + CNT_ONE : cnt_after_pop;
        req_d         = active && (req_hold || (cnt_after_pop != '0));
        maddr_d       = '0;
        mdout_d       = '0;
        if (req_hold && active) begin
            maddr_d = maddr_q;
            mdout_d = mdout_q;
        end else if (req_d) begin
            maddr_d = fifo_addr_q[rd_ptr_d];
            mdout_d = fifo_data_q[rd_ptr_d];
        end
        bcount_d = bcount_q;
        if (start)
            bcount_d = '0;
        else if (pop && !bcount_q[ADDR_W])
            bcount_d = bcount_q + BC_ONE;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        exec_d  = exec_q;
        jaddr_d = jaddr_q;
        ovf_d   = ovf_q | drop;
        case (state_q)
            IDLE: begin
                if (go_rise) begin
                    state_d = LOAD;
                    hold_d  = 1'b1;
                    exec_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else if (bus.execute_enable) begin
                    state_d = JUMP;
                    jaddr_d = bus.execute_addr;
                end
            end
            LOAD: begin
                if (bus.execute_enable) begin
                    exec_d  = 1'b1;
                    jaddr_d = bus.execute_addr;
                end
                if (!bus.dn_go)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.execute_enable) begin
                    exec_d  = 1'b1;
                    jaddr_d = bus.execute_addr;
                end
                if (go_rise) begin
                    state_d = LOAD;
                    hold_d  = 1'b1;
                    exec_d  = 1'b0;
                    ovf_d   = 1'b0;
                end else if ((count_q == '0) && !req_q) begin
                    state_d = exec_d ? JUMP : IDLE;
                    hold_d  = exec_d;
                end
            end
            JUMP: begin
                state_d = IDLE;
                hold_d  = 1'b0;
                exec_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            go_prev_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            maddr_q   <= '0;
            mdout_q   <= '0;
            hold_q    <= 1'b0;
            exec_q    <= 1'b0;
            jaddr_q   <= '0;
            bcount_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            go_prev_q <= bus.dn_go;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            req_q     <= req_d;
            maddr_q   <= maddr_d;
            mdout_q   <= mdout_d;
            hold_q    <= hold_d;
            exec_q    <= exec_d;
            jaddr_q   <= jaddr_d;
            bcount_q  <= bcount_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.dn_addr;
            fifo_data_q[wr_ptr_q] <= bus.dn_data;
        end
    end

`ifdef DN_CHECKSUM_EN
    logic [7:0] csum_q;
    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            csum_q <= '0;
        else if (start)
            csum_q <= '0;
        else if (pop)
            csum_q <= csum_q + mdout_q;
    end
    assign bus.checksum = csum_q;
`else
    assign bus.checksum = 8'h00;
`endif

    assign bus.dn_wait       = (count_q >= WAIT_CNT);
    assign bus.mem_addr      = maddr_q;
    assign bus.mem_dout      = mdout_q;
    assign bus.mem_wr_req    = req_q;
    assign bus.cpu_hold      = hold_q;
    assign bus.cpu_jump      = (state_q == JUMP);
    assign bus.cpu_jump_addr = jaddr_q;
    assign bus.byte_count    = bcount_q;
    assign bus.overflow      = ovf_q;
endmodule

// File: doc/dn_mem_sink.md
Name: dn_mem_sink

Overview:
- Receiving end of the boot/download byte stream (dn_go / dn_wr / dn_addr / dn_data plus execute_addr / execute_enable) driven by the top-level boot loader.
- Buffers incoming bytes in a small FIFO and commits them to a memory write port through a req/ack handshake.
- Holds the CPU in reset while a download is in progress, then issues a single jump request to the execute address once the FIFO has fully drained.

Parameters:
- ADDR_W, 16, width of dn_addr, mem_addr, execute_addr and cpu_jump_addr.
- FIFO_DEPTH, 4, number of buffered {addr,data} entries; must be a power of 2 and at least 2.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dn_go  in  1  download window.
- dn_wr  in  1  byte strobe; valid only while dn_go=1.
- dn_addr  in  ADDR_W  byte address.
- dn_data  in  8  byte value.
- dn_wait  out  1  back-pressure, asserted when FIFO occupancy >= FIFO_DEPTH-1.
- execute_addr  in  ADDR_W  start address for the CPU.
- execute_enable  in  1  one-cycle pulse requesting a jump.
- mem_addr  out  ADDR_W  write address.
- mem_dout  out  8  write data.
- mem_wr_req  out  1  write request; held high until acknowledged.
- mem_ack  in  1  one-cycle acknowledge from memory.
- cpu_hold  out  1  holds the CPU in reset.
- cpu_jump  out  1  one-cycle jump pulse.
- cpu_jump_addr  out  ADDR_W  latched execute address.
- byte_count  out  ADDR_W+1  number of bytes acknowledged by memory.
- overflow  out  1  sticky flag: a byte was dropped.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset (reset_n=0 sampled on a clock edge):
  - State = IDLE; FIFO emptied; exec_pending = 0.
  - All outputs read 0 in the following cycle, including mem_wr_req, even if a request was outstanding.
  - Memory must tolerate an aborted request.
- State IDLE:
  - Rising edge of dn_go (registered previous value) -> LOAD. At that edge: cpu_hold=1, byte_count=0, overflow=0, exec_pending=0, checksum=0.
  - execute_enable while in IDLE -> JUMP; execute_addr is latched.
- State LOAD:
  - Push when dn_go && dn_wr && FIFO not full.
  - dn_wr while the FIFO is full: the byte is dropped and overflow=1.
  - dn_wr while dn_go=0 is ignored in every state.
  - execute_enable sets exec_pending and latches execute_addr into cpu_jump_addr; a later pulse overwrites the latched address.
  - dn_go low -> DRAIN. An execute_enable in that same cycle is still latched.
- State DRAIN:
  - Pops continue; no pushes.
  - Leaves when the FIFO is empty and no request is outstanding: to JUMP if exec_pending, else to IDLE with cpu_hold=0.
  - dn_go rising in DRAIN -> LOAD; counters and flags clear as on the IDLE->LOAD edge; FIFO contents are preserved and still written.
- State JUMP:
  - cpu_jump=1 for exactly one cycle.
  - cpu_hold deasserts the cycle after the jump pulse.
  - Then -> IDLE; exec_pending is cleared.
- Memory side, active in any state except IDLE/JUMP while the FIFO is non-empty:
  - The head entry drives mem_addr/mem_dout with mem_wr_req=1, held stable until mem_ack.
  - On mem_ack: pop the entry and byte_count += 1.
  - If another entry is present, mem_wr_req stays high and the new addr/data appear the next cycle.
  - mem_ack while mem_wr_req=0 is ignored.
- Latency: a byte sampled on dn_wr at edge N drives mem_wr_req=1 after edge N+1, provided the FIFO was empty and no request was outstanding.
- Push and pop in the same cycle: occupancy is unchanged; a push while full is accepted only if the pop occurs in that same cycle.
- Wrap-around:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - byte_count saturates at 2^ADDR_W.
  - dn_addr is passed through unmodified, with no address arithmetic.

Optional Feature:
- Macro: DN_CHECKSUM_EN.
- Defined: checksum is an 8-bit modulo-256 sum of mem_dout, updated on each mem_ack and cleared on the entry edge into LOAD.
- Undefined: checksum is tied to 8'h00 and no adder is synthesised.
- The port exists in both cases.

Test Plan:
- Single write: reset, dn_go rise, dn_wr addr 0x0000 data 0xC3, ack 3 cycles later -> mem_wr_req high from N+1 with 0x0000/0xC3; byte_count=1; cpu_hold=1 throughout; no cpu_jump.
- Full boot: 276 bytes (addr 0..275), one dn_wr every 2 cycles, ack the same cycle as req; execute_enable with addr 0x0000 in the cycle dn_go falls -> byte_count=276; cpu_jump pulses once after the last ack with cpu_jump_addr=0x0000; cpu_hold drops the next cycle.
- Back-pressure: FIFO_DEPTH=4, ack latency 10 cycles, dn_wr on 6 consecutive cycles -> dn_wait high once occupancy reaches 3; bytes 5 and 6 dropped; overflow=1; final byte_count=4.
- Simultaneous: FIFO full, dn_wr in the same cycle as mem_ack -> byte accepted, occupancy stays 4, overflow stays 0.
- Reset mid-transfer: reset_n=0 in LOAD with mem_wr_req=1 -> next cycle mem_wr_req=0, cpu_hold=0, byte_count=0; FIFO empty; a later dn_go rise restarts cleanly.
- DN_CHECKSUM_EN defined: bytes 0x01, 0x02, 0xFF written -> checksum=0x02. Undefined: checksum=0x00.
